// File: rtl/led_matrix_scan_capture.sv
// led_matrix_scan_capture
//   Receiving end of the 8x8 red/green LED matrix scan bus. Watches the
//   multiplexed row scan and samples each row once it has been stable for
//   STABLE_CYCLES cycles. It rebuilds frames in order row 0..7 in a shadow
//   buffer and publishes each complete frame to a readable frame buffer. A
//   publish produces a one-cycle frame_valid pulse.
//
// Parameters
//   STABLE_CYCLES  identical bus cycles required before a row is sampled (1..15)
//   ROW_POL        1: active row bit is 1 (one-hot), 0: active bit is 0 (one-cold)
//
// Ports
//   clk          system clock (same domain as the scan driver)
//   rst          synchronous active-low reset
//   row          row select bus, bit i active selects row i
//   red, green   column data for the active row
//   rd_addr      frame-buffer read row index
//   rd_red       registered red bits of published row rd_addr (1-cycle latency)
//   rd_green     registered green bits of published row rd_addr (1-cycle latency)
//   frame_valid  one-cycle pulse per published frame
//   frame_cnt    published frame count, wraps 255->0
//   row_err      sticky error: illegal row pattern or out-of-sequence row
//   overlap      red&green overlap flag of the last published frame
//
// Optional feature macro: CAPTURE_OVERLAP_EN
//   Defined: overlap is registered at each publish as the OR over all rows of
//   (red & green). Undefined: overlap is tied to 0.

module led_matrix_scan_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int ROW_POL       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] row,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_red,
  output logic [7:0] rd_green,
  output logic       frame_valid,
  output logic [7:0] frame_cnt,
  output logic       row_err,
  output logic       overlap
);

  typedef enum logic [0:0] {
    SYNC    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);

  state_t      state, state_next;
  logic [2:0]  exp_row, exp_row_next;
  logic [23:0] bus_cur, bus_prev;
  logic [3:0]  stable_cnt, cnt_next;
  logic [7:0]  row_norm;
  logic        row_blank, row_one, row_multi;
  logic [2:0]  row_idx;
  logic        sample;
  logic        shadow_we, err_set, publish_set, publish_pend;

  logic [7:0]  shadow_red   [8];
  logic [7:0]  shadow_green [8];
  logic [7:0]  frame_red    [8];
  logic [7:0]  frame_green  [8];

  // Row decode: normalise polarity, classify blank / single / multiple active bits
  always_comb begin
    row_norm  = (ROW_POL != 0) ? row : ~row;
    row_blank = (row_norm == 8'd0);
    row_one   = !row_blank && ((row_norm & (row_norm - 8'd1)) == 8'd0);
    row_multi = !row_blank && !row_one;
    row_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (row_norm[i]) begin
        row_idx = 3'(i);
      end else begin
        row_idx = row_idx;
      end
    end
  end

  // Stability counter next value; the sample fires once, when the count reaches STABLE_LAST
  always_comb begin
    bus_cur  = {row, red, green};
    cnt_next = 4'd0;
    if (row_blank) begin
      cnt_next = 4'd0;
    end else if (bus_cur == bus_prev) begin
      // Saturate so a long hold never wraps back onto STABLE_LAST
      cnt_next = (stable_cnt == 4'd15) ? 4'd15 : stable_cnt + 4'd1;
    end else begin
      cnt_next = 4'd0;
    end
    sample = !row_blank && (cnt_next == STABLE_LAST);
  end

  // Frame-assembly FSM: next state, expected row and buffer control
  always_comb begin
    state_next   = state;
    exp_row_next = exp_row;
    shadow_we    = 1'b0;
    err_set      = 1'b0;
    publish_set  = 1'b0;
    if (sample && row_multi) begin
      err_set      = 1'b1;
      state_next   = SYNC;
      exp_row_next = 3'd0;
    end else if (sample && row_one) begin
      case (state)
        SYNC: begin
          if (row_idx == 3'd0) begin
            shadow_we    = 1'b1;
            exp_row_next = 3'd1;
            state_next   = CAPTURE;
          end else begin
            state_next = SYNC;
          end
        end
        CAPTURE: begin
          if (row_idx == exp_row) begin
            shadow_we = 1'b1;
            if (row_idx == 3'd7) begin
              publish_set  = 1'b1;
              exp_row_next = 3'd0;
              state_next   = SYNC;
            end else begin
              exp_row_next = exp_row + 3'd1;
            end
          end else begin
            err_set = 1'b1;
            // An out-of-order row 0 starts a fresh frame at once
            if (row_idx == 3'd0) begin
              shadow_we    = 1'b1;
              exp_row_next = 3'd1;
              state_next   = CAPTURE;
            end else begin
              exp_row_next = 3'd0;
              state_next   = SYNC;
            end
          end
        end
        default: begin
          exp_row_next = 3'd0;
          state_next   = SYNC;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

  // State, capture, publish and read-port registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= SYNC;
      exp_row      <= 3'd0;
      bus_prev     <= 24'd0;
      stable_cnt   <= 4'd0;
      publish_pend <= 1'b0;
      frame_valid  <= 1'b0;
      frame_cnt    <= 8'd0;
      row_err      <= 1'b0;
      rd_red       <= 8'd0;
      rd_green     <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        shadow_red[i]   <= 8'd0;
        shadow_green[i] <= 8'd0;
        frame_red[i]    <= 8'd0;
        frame_green[i]  <= 8'd0;
      end
    end else begin
      state        <= state_next;
      exp_row      <= exp_row_next;
      bus_prev     <= bus_cur;
      stable_cnt   <= cnt_next;
      publish_pend <= publish_set;
      frame_valid  <= publish_pend;
      if (shadow_we) begin
        shadow_red[row_idx]   <= red;
        shadow_green[row_idx] <= green;
      end
      if (err_set) begin
        row_err <= 1'b1;
      end
      // Publish one edge after row 7 lands so the shadow copy includes row 7
      if (publish_pend) begin
        frame_cnt <= frame_cnt + 8'd1;
        for (int i = 0; i < 8; i++) begin
          frame_red[i]   <= shadow_red[i];
          frame_green[i] <= shadow_green[i];
        end
      end
      // Reads see the pre-publish contents during a publish edge
      rd_red   <= frame_red[rd_addr];
      rd_green <= frame_green[rd_addr];
    end
  end

`ifdef CAPTURE_OVERLAP_EN
  logic ovl_next;

  // Overlap of the shadow frame about to be published
  always_comb begin
    ovl_next = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ovl_next = ovl_next | (|(shadow_red[i] & shadow_green[i]));
    end
  end

  // Overlap flag, refreshed at each publish
  always_ff @(posedge clk) begin
    if (!rst) begin
      overlap <= 1'b0;
    end else if (publish_pend) begin
      overlap <= ovl_next;
    end else begin
      overlap <= overlap;
    end
  end
`else
  assign overlap = 1'b0;
`endif

endmodule

// File: tb/tb_led_matrix_scan_capture.sv
// Directed testbench for led_matrix_scan_capture (STABLE_CYCLES=4, ROW_POL=1).
// Inputs change 1 time unit after a rising edge; outputs are checked on falling edges.

module tb_led_matrix_scan_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] row, red, green;
  logic [2:0] rd_addr;
  logic [7:0] rd_red, rd_green, frame_cnt;
  logic       frame_valid, row_err, overlap;

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int fv_total = 0;
  int fv_base;
  logic exp_ov;

  led_matrix_scan_capture #(.STABLE_CYCLES(4), .ROW_POL(1)) dut (
    .clk(clk), .rst(rst), .row(row), .red(red), .green(green),
    .rd_addr(rd_addr), .rd_red(rd_red), .rd_green(rd_green),
    .frame_valid(frame_valid), .frame_cnt(frame_cnt),
    .row_err(row_err), .overlap(overlap)
  );

  always #5 clk = ~clk;

  // Counts frame_valid cycles
  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_total <= fv_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  // Hold one bus value for n rising edges
  task automatic send_row(input logic [7:0] r, input logic [7:0] rd, input logic [7:0] gr, input int n);
    row = r; red = rd; green = gr;
    repeat (n) to_pos();
  endtask

  task automatic send_idx(input int i, input int n);
    logic [7:0] r, gr;
    r  = 8'h01 << i;
    gr = 8'h80 >> i;
    send_row(r, r, gr, n);
  endtask

  // Rows 0..7 with red=1<<i, green=0x80>>i; ov makes row 5 green equal red
  task automatic send_frame(input int n, input bit ov);
    for (int i = 0; i < 8; i++) begin
      if (ov && i == 5) send_row(8'h20, 8'h20, 8'h20, n);
      else send_idx(i, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; row = 8'h00; red = 8'h00; green = 8'h00;
    repeat (3) to_pos();
    rst = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    to_neg();
    check({tag, ".rd_red"}, 32'(rd_red), 32'h0);
    check({tag, ".rd_green"}, 32'(rd_green), 32'h0);
    check({tag, ".frame_valid"}, 32'(frame_valid), 32'h0);
    check({tag, ".frame_cnt"}, 32'(frame_cnt), 32'h0);
    check({tag, ".row_err"}, 32'(row_err), 32'h0);
    check({tag, ".overlap"}, 32'(overlap), 32'h0);
    to_pos();
  endtask

  task automatic check_read(input string tag, input logic [2:0] a, input logic [7:0] er, input logic [7:0] eg);
    rd_addr = a;
    to_pos();
    to_neg();
    check({tag, ".rd_red"}, 32'(rd_red), 32'(er));
    check({tag, ".rd_green"}, 32'(rd_green), 32'(eg));
    to_pos();
  endtask

  initial begin
`ifdef CAPTURE_OVERLAP_EN
    exp_ov = 1'b1;
`else
    exp_ov = 1'b0;
`endif
    rd_addr = 3'd0;
    do_reset();
    check_zero("reset");

    // 1: clean frame, 6 cycles per row
    fv_base = fv_total;
    send_frame(6, 1'b0);
    send_row(8'h00, 8'h00, 8'h00, 3);
    check("t1.pulses", 32'(fv_total - fv_base), 32'd1);
    check("t1.frame_cnt", 32'(frame_cnt), 32'd1);
    check("t1.row_err", 32'(row_err), 32'd0);
    check_read("t1.r3", 3'd3, 8'h08, 8'h10);
    check_read("t1.r0", 3'd0, 8'h01, 8'h80);
    check_read("t1.r7", 3'd7, 8'h80, 8'h01);

    // 2: rows held only 3 cycles are never sampled
    fv_base = fv_total;
    send_frame(3, 1'b0);
    send_row(8'h00, 8'h00, 8'h00, 3);
    check("t2.pulses", 32'(fv_total - fv_base), 32'd0);
    check("t2.frame_cnt", 32'(frame_cnt), 32'd1);
    check("t2.row_err", 32'(row_err), 32'd0);

    // 3: sequence 0,1,2,4 flags error; following clean frame still publishes
    fv_base = fv_total;
    send_idx(0, 6); send_idx(1, 6); send_idx(2, 6); send_idx(4, 6);
    send_row(8'h00, 8'h00, 8'h00, 3);
    check("t3.err", 32'(row_err), 32'd1);
    check("t3.nopub", 32'(fv_total - fv_base), 32'd0);
    send_frame(6, 1'b0);
    send_row(8'h00, 8'h00, 8'h00, 3);
    check("t3.frame_cnt", 32'(frame_cnt), 32'd2);
    check("t3.err_sticky", 32'(row_err), 32'd1);

    // 4: illegal row pattern; blanks between rows; illegal mid-frame aborts frame
    do_reset();
    check_zero("reset2");
    send_row(8'h11, 8'h55, 8'hAA, 6);
    send_row(8'h00, 8'h00, 8'h00, 2);
    check("t4.illegal", 32'(row_err), 32'd1);
    do_reset();
    fv_base = fv_total;
    for (int i = 0; i < 8; i++) begin
      send_idx(i, 5);
      send_row(8'h00, 8'h00, 8'h00, 2);
    end
    send_row(8'h00, 8'h00, 8'h00, 2);
    check("t4.blank_pub", 32'(fv_total - fv_base), 32'd1);
    check("t4.blank_cnt", 32'(frame_cnt), 32'd1);
    check("t4.blank_err", 32'(row_err), 32'd0);
    fv_base = fv_total;
    for (int i = 0; i < 4; i++) send_idx(i, 6);
    send_row(8'h11, 8'h00, 8'h00, 6);
    for (int i = 4; i < 8; i++) send_idx(i, 6);
    send_row(8'h00, 8'h00, 8'h00, 3);
    check("t4.abort_pub", 32'(fv_total - fv_base), 32'd0);
    check("t4.abort_err", 32'(row_err), 32'd1);
    check("t4.abort_cnt", 32'(frame_cnt), 32'd1);

    // 5: 256 frames wrap the counter; reset mid-frame
    do_reset();
    fv_base = fv_total;
    for (int f = 0; f < 255; f++) send_frame(4, 1'b0);
    send_row(8'h00, 8'h00, 8'h00, 3);
    check("t5.cnt255", 32'(frame_cnt), 32'd255);
    check("t5.pulses255", 32'(fv_total - fv_base), 32'd255);
    send_frame(4, 1'b0);
    send_row(8'h00, 8'h00, 8'h00, 3);
    check("t5.wrap", 32'(frame_cnt), 32'd0);
    check("t5.wrap_err", 32'(row_err), 32'd0);
    check_read("t5.r5", 3'd5, 8'h20, 8'h04);
    for (int i = 0; i < 5; i++) send_idx(i, 6);
    do_reset();
    check_zero("t5.midreset");
    fv_base = fv_total;
    send_frame(6, 1'b0);
    send_row(8'h00, 8'h00, 8'h00, 3);
    check("t5.after_pub", 32'(fv_total - fv_base), 32'd1);
    check("t5.after_cnt", 32'(frame_cnt), 32'd1);
    check_read("t5.after_r5", 3'd5, 8'h20, 8'h04);

    // 6: overlap flag follows the last published frame
    send_frame(6, 1'b1);
    send_row(8'h00, 8'h00, 8'h00, 3);
    check("t6.ov_set", 32'(overlap), 32'(exp_ov));
    check_read("t6.r5", 3'd5, 8'h20, 8'h20);
    send_frame(6, 1'b0);
    send_row(8'h00, 8'h00, 8'h00, 3);
    check("t6.ov_clr", 32'(overlap), 32'd0);
    check("t6.cnt", 32'(frame_cnt), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
